// File: rtl/rv32i_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_mem_responder_pkg
//   Shared constants for the rv32i memory responder and its users.
//   MEM_WR_* are the byte-lane write masks the CPU drives on data_mem_wmask
//   for byte, halfword and word stores (lane 0 aligned; the CPU shifts them).
//   MEM_LAT_MAX bounds the read pipeline depth of both ports.
// -----------------------------------------------------------------------------
package rv32i_mem_responder_pkg;

    localparam logic [3:0] MEM_WR_BYTE = 4'b0001;
    localparam logic [3:0] MEM_WR_HALF = 4'b0011;
    localparam logic [3:0] MEM_WR_WORD = 4'b1111;

    localparam int MEM_LAT_MAX = 2;

endpackage

// File: rtl/rv32i_mem_rdpipe.sv
// -----------------------------------------------------------------------------
// rv32i_mem_rdpipe
//   Resettable shift register carrying read data from the array to a port
//   output. STAGES registers deep; the output only moves when the pipe shifts.
// Ports:
//   clk      in   1      clock (posedge)
//   reset    in   1      synchronous active-high; clears every stage
//   d_i      in   WIDTH  data entering stage 0
//   q_o      out  WIDTH  last stage
// -----------------------------------------------------------------------------
module rv32i_mem_rdpipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < STAGES; s++) begin
                stage_q[s] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int s = 1; s < STAGES; s++) begin
                stage_q[s] <= stage_q[s-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/rv32i_mem_responder.sv
// -----------------------------------------------------------------------------
// rv32i_mem_responder
//   Dual-port word memory for rv32i_cpu. Port I is a read-only fetch port,
//   port D is a read/write data port. There is no request strobe: each port
//   reads its address every cycle and data returns READ_LATENCY clocks later.
//   Out-of-range accesses read as zero, drop writes and set a sticky fault.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   inst_addr         in   IMEM_WIDTH  fetch byte address
//   instruction_data  out  32          fetched word
//   data_mem_addr     in   DMEM_WIDTH  data byte address
//   data_mem_wmask    in   4           byte-lane write enables
//   data_mem_write    in   32          lane-shifted write data
//   data_mem_w_en     in   1           write strobe
//   data_mem_read     out  32          data read word
//   fault             out  1           sticky out-of-range flag
//   fault_addr        out  32          first faulting byte address
//   write_count       out  32          accepted write counter (wraps)
// -----------------------------------------------------------------------------
module rv32i_mem_responder
    import rv32i_mem_responder_pkg::*;
#(
    parameter int    IMEM_WIDTH   = 32,
    parameter int    DMEM_WIDTH   = 32,
    parameter int    DEPTH_WORDS  = 4096,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = ""
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [IMEM_WIDTH-1:0] inst_addr,
    output logic [31:0]           instruction_data,
    input  logic [DMEM_WIDTH-1:0] data_mem_addr,
    input  logic [3:0]            data_mem_wmask,
    input  logic [31:0]           data_mem_write,
    input  logic                  data_mem_w_en,
    output logic [31:0]           data_mem_read,
    output logic                  fault,
    output logic [31:0]           fault_addr,
    output logic [31:0]           write_count
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    if ((READ_LATENCY < 1) || (READ_LATENCY > MEM_LAT_MAX)) begin : g_bad_latency
        $error("rv32i_mem_responder: READ_LATENCY must be 1..%0d", MEM_LAT_MAX);
    end
    if (((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) || (DEPTH_WORDS < 16)) begin : g_bad_depth
        $error("rv32i_mem_responder: DEPTH_WORDS must be a power of two >= 16");
    end

    logic [31:0] mem [0:DEPTH_WORDS-1];

    // Address decode: index field sits above the byte offset; anything set
    // above the index field puts the access out of range.
    logic [IDX_W-1:0] i_idx;
    logic [IDX_W-1:0] d_idx;
    logic             i_oor;
    logic             d_oor;

    assign i_idx = inst_addr[IDX_W+1:2];
    assign d_idx = data_mem_addr[IDX_W+1:2];
    assign i_oor = (inst_addr >> (IDX_W + 2)) != '0;
    assign d_oor = (data_mem_addr >> (IDX_W + 2)) != '0;

    logic d_wr_accept;
    assign d_wr_accept = !reset && data_mem_w_en && !d_oor && (data_mem_wmask != 4'b0000);

    // Array reads are taken before the write lands at the same edge, which
    // gives read-first behaviour on both ports.
    logic [31:0] i_rd_word;
    logic [31:0] d_rd_word;
    assign i_rd_word = i_oor ? 32'h0 : mem[i_idx];
    assign d_rd_word = d_oor ? 32'h0 : mem[d_idx];

    always_ff @(posedge clk) begin
        if (d_wr_accept) begin
            for (int n = 0; n < 4; n++) begin
                if (data_mem_wmask[n]) begin
                    mem[d_idx][8*n +: 8] <= data_mem_write[8*n +: 8];
                end
            end
        end
    end

    rv32i_mem_rdpipe #(
        .WIDTH  (32),
        .STAGES (READ_LATENCY)
    ) u_ipipe (
        .clk   (clk),
        .reset (reset),
        .d_i   (i_rd_word),
        .q_o   (instruction_data)
    );

    rv32i_mem_rdpipe #(
        .WIDTH  (32),
        .STAGES (READ_LATENCY)
    ) u_dpipe (
        .clk   (clk),
        .reset (reset),
        .d_i   (d_rd_word),
        .q_o   (data_mem_read)
    );

    logic        fault_q, fault_d;
    logic [31:0] fault_addr_q, fault_addr_d;
    logic [31:0] wcount_q, wcount_d;

    always_comb begin
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        wcount_d     = wcount_q;
        // Only the first fault is recorded; D beats I when both fault together.
        if (!fault_q) begin
            if (d_oor) begin
                fault_addr_d = 32'(data_mem_addr);
            end else if (i_oor) begin
                fault_addr_d = 32'(inst_addr);
            end
        end
        if (i_oor || d_oor) begin
            fault_d = 1'b1;
        end
        if (d_wr_accept) begin
            wcount_d = wcount_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fault_q      <= 1'b0;
            fault_addr_q <= 32'h0;
            wcount_q     <= 32'h0;
        end else begin
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
            wcount_q     <= wcount_d;
        end
    end

    assign fault       = fault_q;
    assign fault_addr  = fault_addr_q;
    assign write_count = wcount_q;

endmodule

// File: tb/tb_rv32i_mem_responder.sv
module tb_rv32i_mem_responder;
    import rv32i_mem_responder_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---- DUT A: 4096 words, latency 1 ----
    logic        reset;
    logic [31:0] ia, da, wd;
    logic [3:0]  wm;
    logic        we;
    logic [31:0] instr, rdata, faddr, wcnt;
    logic        flt;

    rv32i_mem_responder #(
        .IMEM_WIDTH(32), .DMEM_WIDTH(32), .DEPTH_WORDS(4096), .READ_LATENCY(1), .INIT_FILE("")
    ) dut (
        .clk(clk), .reset(reset),
        .inst_addr(ia), .instruction_data(instr),
        .data_mem_addr(da), .data_mem_wmask(wm), .data_mem_write(wd), .data_mem_w_en(we),
        .data_mem_read(rdata), .fault(flt), .fault_addr(faddr), .write_count(wcnt)
    );

    // ---- DUT B: 16 words, latency 2 ----
    logic        rst2;
    logic [31:0] b_ia, b_da, b_wd;
    logic [3:0]  b_wm;
    logic        b_we;
    logic [31:0] b_instr, b_rdata, b_faddr, b_wcnt;
    logic        b_flt;

    rv32i_mem_responder #(
        .IMEM_WIDTH(32), .DMEM_WIDTH(32), .DEPTH_WORDS(16), .READ_LATENCY(2), .INIT_FILE("")
    ) dut2 (
        .clk(clk), .reset(rst2),
        .inst_addr(b_ia), .instruction_data(b_instr),
        .data_mem_addr(b_da), .data_mem_wmask(b_wm), .data_mem_write(b_wd), .data_mem_w_en(b_we),
        .data_mem_read(b_rdata), .fault(b_flt), .fault_addr(b_faddr), .write_count(b_wcnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_a(input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
        da = addr; wm = mask; wd = data; we = 1'b1;
        tick();
        we = 1'b0; wm = 4'b0000;
    endtask

    task automatic wr_b(input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
        b_da = addr; b_wm = mask; b_wd = data; b_we = 1'b1;
        tick();
        b_we = 1'b0; b_wm = 4'b0000;
    endtask

    initial begin
        reset = 1'b1; ia = 32'h0; da = 32'h0; wd = 32'h0; wm = 4'b0000; we = 1'b0;
        rst2  = 1'b1; b_ia = 32'h0; b_da = 32'h0; b_wd = 32'h0; b_wm = 4'b0000; b_we = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_instr", instr, 32'h0);
        check("rst_read", rdata, 32'h0);
        check("rst_fault", {31'h0, flt}, 32'h0);
        check("rst_faddr", faddr, 32'h0);
        check("rst_wcnt", wcnt, 32'h0);
        check("rst_b_read", b_rdata, 32'h0);
        check("rst_b_instr", b_instr, 32'h0);
        reset = 1'b0;
        rst2  = 1'b0;

        // Preload, then reset mid-load: counter clears, contents survive
        wr_a(32'd12, MEM_WR_WORD, 32'h00A0_0093);
        wr_a(32'd16, MEM_WR_WORD, 32'h1122_3344);
        wr_a(32'd20, MEM_WR_WORD, 32'h0000_0000);
        check("preload_wcnt", wcnt, 32'd3);
        da = 32'd16;
        reset = 1'b1;
        wr_a(32'd16, MEM_WR_WORD, 32'hFFFF_FFFF);  // suppressed by reset
        reset = 1'b0;
        check("t6_read0", rdata, 32'h0);
        check("t6_wcnt0", wcnt, 32'h0);
        check("t6_fault0", {31'h0, flt}, 32'h0);
        tick();
        check("t6_preserved", rdata, 32'h1122_3344);

        // T1 fetch
        ia = 32'd12;
        tick();
        check("t1_instr", instr, 32'h00A0_0093);
        check("t1_fault", {31'h0, flt}, 32'h0);

        // T2 byte / half stores
        wr_a(32'd16, 4'b0100, 32'h00AB_0000);
        tick();
        check("t2_byte", rdata, 32'h11AB_3344);
        wr_a(32'd16, 4'b1100, 32'hBEEF_0000);
        tick();
        check("t2_half", rdata, 32'hBEEF_3344);
        check("t2_wcnt", wcnt, 32'd2);
        wr_a(32'd16, 4'b0000, 32'hFFFF_FFFF);
        tick();
        check("t2_nomask_data", rdata, 32'hBEEF_3344);
        check("t2_nomask_wcnt", wcnt, 32'd2);

        // T3 read-first, D and I ports on the written word
        ia = 32'd20;
        wr_a(32'd20, MEM_WR_WORD, 32'hDEAD_BEEF);
        check("t3_d_old", rdata, 32'h0);
        check("t3_i_old", instr, 32'h0);
        tick();
        check("t3_d_new", rdata, 32'hDEAD_BEEF);
        check("t3_i_new", instr, 32'hDEAD_BEEF);

        // T5 store then load of word 0, load address has only low bits set
        wr_a(32'd0, MEM_WR_WORD, 32'd5);
        da = 32'd3;
        tick();
        check("t5_load", rdata, 32'd5);
        check("t5_nofault", {31'h0, flt}, 32'h0);

        // Last word is in range
        wr_a(32'h0000_3FFC, MEM_WR_WORD, 32'h1234_5678);
        tick();
        check("last_word", rdata, 32'h1234_5678);
        check("last_nofault", {31'h0, flt}, 32'h0);
        check("last_wcnt", wcnt, 32'd5);

        // T4 out-of-range write
        wr_a(32'h0000_4000, MEM_WR_WORD, 32'hCAFE_F00D);
        check("t4_fault", {31'h0, flt}, 32'h1);
        check("t4_faddr", faddr, 32'h0000_4000);
        check("t4_read0", rdata, 32'h0);
        check("t4_wcnt", wcnt, 32'd5);
        da = 32'd0;
        tick();
        check("t4_no_alias", rdata, 32'd5);
        ia = 32'h0001_0000;
        tick();
        check("t4_i_oor", instr, 32'h0);
        check("t4_faddr_kept", faddr, 32'h0000_4000);

        // Simultaneous I and D fault: D address recorded
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ia = 32'h0000_8000;
        da = 32'h0000_4004;
        tick();
        check("both_fault", {31'h0, flt}, 32'h1);
        check("both_faddr", faddr, 32'h0000_4004);

        // ---- DUT B: latency 2, 16 words ----
        wr_b(32'd20, MEM_WR_WORD, 32'h0);
        wr_b(32'd60, MEM_WR_WORD, 32'hA5A5_A5A5);
        b_da = 32'd20; b_wm = MEM_WR_WORD; b_wd = 32'hDEAD_BEEF; b_we = 1'b1;
        tick();
        b_we = 1'b0; b_wm = 4'b0000;
        tick();
        check("b_t3_old", b_rdata, 32'h0);
        tick();
        check("b_t3_new", b_rdata, 32'hDEAD_BEEF);

        b_da = 32'd60;
        rst2 = 1'b1;
        tick();
        rst2 = 1'b0;
        check("b_rst_read", b_rdata, 32'h0);
        check("b_rst_wcnt", b_wcnt, 32'h0);
        tick();
        check("b_rst_lat1", b_rdata, 32'h0);
        tick();
        check("b_rst_lat2", b_rdata, 32'hA5A5_A5A5);
        check("b_last_nofault", {31'h0, b_flt}, 32'h0);

        b_ia = 32'd60;
        b_da = 32'd64;
        tick();
        tick();
        check("b_i_last", b_instr, 32'hA5A5_A5A5);
        check("b_oor_read", b_rdata, 32'h0);
        check("b_oor_fault", {31'h0, b_flt}, 32'h1);
        check("b_oor_faddr", b_faddr, 32'd64);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
